// File: rtl/led_pwm_seq_if.sv
// rtl/led_pwm_seq_if.sv - button inputs and LED/status outputs of the LED PWM sequencer
interface led_pwm_seq_if;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic [7:0] led;
    logic [1:0] mode;
    logic [3:0] level;

    modport master (
        output btn_mode,
        output btn_up,
        output btn_down,
        input  led,
        input  mode,
        input  level
    );

    modport slave (
        input  btn_mode,
        input  btn_up,
        input  btn_down,
        output led,
        output mode,
        output level
    );
endinterface

// File: rtl/led_pwm_seq.sv
// rtl/led_pwm_seq.sv - 8-LED brightness sequencer: shared PWM frame, MANUAL/BREATHE/CHASE/OFF modes
module led_pwm_seq #(
    parameter int CLK_DIV     = 1000,
    parameter int PWM_MAX     = 9,
    parameter int STEP_FRAMES = 20
) (
    input  logic          clk,
    input  logic          rst,
    led_pwm_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        MANUAL  = 2'd0,
        BREATHE = 2'd1,
        CHASE   = 2'd2,
        OFF     = 2'd3
    } mode_t;

    logic [1:0]       r_sync_mode, r_sync_up, r_sync_dn;
    logic [15:0]      r_divcnt;
    logic [3:0]       r_pcnt;
    logic [7:0]       r_scnt;
    mode_t            r_mode;
    logic [3:0]       r_man;
    logic [3:0]       r_br;
    logic             r_dir;
    logic [2:0]       r_pos;
    logic [7:0][3:0]  r_duty;
    logic [7:0]       r_led;
    logic [3:0]       r_level;

    logic             w_pls_mode, w_pls_up, w_pls_dn;
    logic             w_tick, w_frame_end, w_step, w_latch;
    mode_t            w_mode_nxt;
    logic [3:0]       w_man_nxt, w_br_nxt, w_level_nxt;
    logic             w_dir_nxt;
    logic [2:0]       w_pos_nxt;
    logic [7:0]       w_scnt_nxt;
    logic [7:0][3:0]  w_duty;

    assign w_pls_mode  = r_sync_mode[0] & ~r_sync_mode[1];
    assign w_pls_up    = r_sync_up[0] & ~r_sync_up[1];
    assign w_pls_dn    = r_sync_dn[0] & ~r_sync_dn[1];

    assign w_tick      = (r_divcnt == 16'(CLK_DIV - 1));
    assign w_frame_end = w_tick & (r_pcnt == 4'(PWM_MAX - 1));
    assign w_step      = w_frame_end & (r_scnt == 8'(STEP_FRAMES - 1));

    // A mode change wins over a same-cycle step; the step is simply dropped.
    always_comb begin
        w_mode_nxt = r_mode;
        w_man_nxt  = r_man;
        w_br_nxt   = r_br;
        w_dir_nxt  = r_dir;
        w_pos_nxt  = r_pos;
        w_scnt_nxt = r_scnt;
        if (w_frame_end) begin
            w_scnt_nxt = w_step ? 8'd0 : r_scnt + 8'd1;
        end
        if (w_pls_mode) begin
            w_mode_nxt = mode_t'(r_mode + 2'd1);
            if (w_mode_nxt == BREATHE) begin
                w_br_nxt   = 4'd0;
                w_dir_nxt  = 1'b0;
                w_scnt_nxt = 8'd0;
            end else if (w_mode_nxt == CHASE) begin
                w_pos_nxt  = 3'd0;
                w_scnt_nxt = 8'd0;
            end
        end else begin
            case (r_mode)
                MANUAL: begin
                    if (w_pls_up && !w_pls_dn && r_man != 4'(PWM_MAX)) begin
                        w_man_nxt = r_man + 4'd1;
                    end else if (w_pls_dn && !w_pls_up && r_man != 4'd0) begin
                        w_man_nxt = r_man - 4'd1;
                    end
                end
                BREATHE: begin
                    if (w_step) begin
                        if (!r_dir) begin
                            w_br_nxt = r_br + 4'd1;
                            if (r_br + 4'd1 == 4'(PWM_MAX)) w_dir_nxt = 1'b1;
                        end else begin
                            w_br_nxt = r_br - 4'd1;
                            if (r_br - 4'd1 == 4'd0) w_dir_nxt = 1'b0;
                        end
                    end
                end
                CHASE: begin
                    if (w_step) w_pos_nxt = r_pos + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Duties are derived from the post-update state so a step shows up in the frame it starts.
    always_comb begin
        w_duty      = '0;
        w_level_nxt = 4'd0;
        case (w_mode_nxt)
            MANUAL: begin
                for (int i = 0; i < 8; i++) w_duty[i] = w_man_nxt;
                w_level_nxt = w_man_nxt;
            end
            BREATHE: begin
                for (int i = 0; i < 8; i++) w_duty[i] = w_br_nxt;
                w_level_nxt = w_br_nxt;
            end
            CHASE: begin
                w_duty[w_pos_nxt - 3'd1] = 4'(PWM_MAX >> 1);
                w_duty[w_pos_nxt]        = 4'(PWM_MAX);
                w_level_nxt              = 4'(PWM_MAX);
            end
            default: ;
        endcase
    end

    assign w_latch = w_frame_end | ((w_mode_nxt == OFF) && (r_mode != OFF));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_mode <= 2'b00;
            r_sync_up   <= 2'b00;
            r_sync_dn   <= 2'b00;
            r_divcnt    <= 16'd0;
            r_pcnt      <= 4'd0;
            r_scnt      <= 8'd0;
            r_mode      <= MANUAL;
            r_man       <= 4'd0;
            r_br        <= 4'd0;
            r_dir       <= 1'b0;
            r_pos       <= 3'd0;
            r_duty      <= '0;
            r_led       <= 8'h00;
            r_level     <= 4'd0;
        end else begin
            r_sync_mode <= {r_sync_mode[0], bus.btn_mode};
            r_sync_up   <= {r_sync_up[0], bus.btn_up};
            r_sync_dn   <= {r_sync_dn[0], bus.btn_down};
            r_divcnt    <= w_tick ? 16'd0 : r_divcnt + 16'd1;
            if (w_tick) begin
                r_pcnt <= w_frame_end ? 4'd0 : r_pcnt + 4'd1;
            end
            r_scnt  <= w_scnt_nxt;
            r_mode  <= w_mode_nxt;
            r_man   <= w_man_nxt;
            r_br    <= w_br_nxt;
            r_dir   <= w_dir_nxt;
            r_pos   <= w_pos_nxt;
            r_level <= w_level_nxt;
            if (w_latch) r_duty <= w_duty;
            for (int i = 0; i < 8; i++) begin
                r_led[i] <= (r_pcnt < r_duty[i]);
            end
        end
    end

    assign bus.led   = r_led;
    assign bus.mode  = r_mode;
    assign bus.level = r_level;
endmodule

// File: tb/tb_led_pwm_seq.sv
// tb/tb_led_pwm_seq.sv - directed bench for led_pwm_seq with CLK_DIV=1, PWM_MAX=9, STEP_FRAMES=2
module tb_led_pwm_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    led_pwm_seq_if bus ();

    led_pwm_seq #(.CLK_DIV(1), .PWM_MAX(9), .STEP_FRAMES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic press(input logic m, input logic u, input logic d);
        @(negedge clk);
        bus.btn_mode = m;
        bus.btn_up   = u;
        bus.btn_down = d;
        repeat (3) @(negedge clk);
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", bus.led); end
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", bus.mode); end
        checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
        rst = 1'b1;
    endtask

    task automatic test_manual_up;
        int n;
        int bad;
        repeat (3) press(1'b0, 1'b1, 1'b0);
        checks++; if (bus.level !== 4'd3) begin errors++; $display("FAIL up3_level: got %0d expected 3", bus.level); end
        repeat (20) @(negedge clk);
        n = 0; bad = 0;
        repeat (9) begin
            @(negedge clk);
            if (bus.led === 8'hFF) n++;
            else if (bus.led !== 8'h00) bad++;
        end
        checks++; if (n != 3 || bad != 0) begin errors++; $display("FAIL up3_duty: got high=%0d partial=%0d expected high=3 partial=0", n, bad); end
        repeat (12) press(1'b0, 1'b1, 1'b0);
        checks++; if (bus.level !== 4'd9) begin errors++; $display("FAIL up_sat_level: got %0d expected 9", bus.level); end
        repeat (20) @(negedge clk);
        n = 0;
        repeat (18) begin @(negedge clk); if (bus.led === 8'hFF) n++; end
        checks++; if (n != 18) begin errors++; $display("FAIL up_sat_led: got %0d of 18 high expected 18", n); end
    endtask

    task automatic test_manual_down;
        int n;
        repeat (4) press(1'b0, 1'b0, 1'b1);
        checks++; if (bus.level !== 4'd5) begin errors++; $display("FAIL down4_level: got %0d expected 5", bus.level); end
        press(1'b0, 1'b1, 1'b1);
        checks++; if (bus.level !== 4'd5) begin errors++; $display("FAIL updown_level: got %0d expected 5", bus.level); end
        repeat (6) press(1'b0, 1'b0, 1'b1);
        checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL down_sat_level: got %0d expected 0", bus.level); end
        repeat (20) @(negedge clk);
        n = 0;
        repeat (18) begin @(negedge clk); if (bus.led === 8'h00) n++; end
        checks++; if (n != 18) begin errors++; $display("FAIL down_sat_led: got %0d of 18 low expected 18", n); end
        repeat (2) press(1'b0, 1'b1, 1'b0);
        checks++; if (bus.level !== 4'd2) begin errors++; $display("FAIL up2_level: got %0d expected 2", bus.level); end
    endtask

    task automatic test_breathe;
        int exp_seq[19];
        logic [3:0] prev;
        int tlast;
        int t;
        int n;
        bit found;
        for (int k = 0; k < 9; k++) exp_seq[k] = k + 1;
        for (int k = 0; k < 9; k++) exp_seq[9 + k] = 8 - k;
        exp_seq[18] = 1;
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL breathe_mode: got %0d expected 1", bus.mode); end
        checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL breathe_start: got %0d expected 0", bus.level); end
        prev = bus.level;
        tlast = 0;
        for (int i = 0; i < 19; i++) begin
            found = 1'b0; t = 0;
            while (!found && t < 40) begin
                @(negedge clk); t++;
                if (bus.level !== prev) found = 1'b1;
            end
            checks++;
            if (!found) begin
                errors++; $display("FAIL breathe_timeout: step %0d level stuck at %0d expected %0d", i, prev, exp_seq[i]);
            end else begin
                if (bus.level !== 4'(exp_seq[i])) begin errors++; $display("FAIL breathe_level: step %0d got %0d expected %0d", i, bus.level, exp_seq[i]); end
                if (i > 0) begin
                    checks++;
                    if (cyc - tlast != 18) begin errors++; $display("FAIL breathe_period: step %0d got %0d clk expected 18", i, cyc - tlast); end
                end
                tlast = cyc;
                prev = bus.level;
                @(negedge clk);
                n = 0;
                repeat (9) begin @(negedge clk); if (bus.led === 8'hFF) n++; end
                checks++;
                if (n != exp_seq[i]) begin errors++; $display("FAIL breathe_duty: step %0d got %0d high expected %0d", i, n, exp_seq[i]); end
            end
        end
    endtask

    task automatic test_chase;
        int p;
        int pp;
        int t;
        int tlast;
        int hi;
        int lo;
        int oth;
        bit found;
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.mode !== 2'd2) begin errors++; $display("FAIL chase_mode: got %0d expected 2", bus.mode); end
        checks++; if (bus.level !== 4'd9) begin errors++; $display("FAIL chase_level: got %0d expected 9", bus.level); end
        tlast = 0;
        for (int i = 0; i < 9; i++) begin
            p  = i % 8;
            pp = (p + 7) % 8;
            found = 1'b0; t = 0;
            while (!found && t < 60) begin
                @(negedge clk); t++;
                if (bus.led === (8'h01 << p)) found = 1'b1;
            end
            checks++;
            if (!found) begin
                errors++; $display("FAIL chase_timeout: pos %0d never seen alone, led=%h", p, bus.led);
            end else begin
                if (i >= 2) begin
                    checks++;
                    if (cyc - tlast != 18) begin errors++; $display("FAIL chase_period: pos %0d got %0d clk expected 18", p, cyc - tlast); end
                end
                tlast = cyc;
                if (i >= 1) begin
                    hi = 0; lo = 0; oth = 0;
                    repeat (9) begin
                        @(negedge clk);
                        for (int b = 0; b < 8; b++) begin
                            if (bus.led[b] === 1'b1) begin
                                if (b == p) hi++;
                                else if (b == pp) lo++;
                                else oth++;
                            end
                        end
                    end
                    checks++;
                    if (hi != 9 || lo != 4 || oth != 0) begin
                        errors++; $display("FAIL chase_duty: pos %0d got hi=%0d trail=%0d other=%0d expected 9/4/0", p, hi, lo, oth);
                    end
                end
            end
        end
    endtask

    task automatic test_off;
        int n;
        @(negedge clk);
        bus.btn_mode = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL off_mode: got %0d expected 3", bus.mode); end
        checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL off_level: got %0d expected 0", bus.level); end
        @(negedge clk);
        checks++; if (bus.led !== 8'h00) begin errors++; $display("FAIL off_led_now: got %h expected 00", bus.led); end
        bus.btn_mode = 1'b0;
        repeat (3) @(negedge clk);
        n = 0;
        repeat (18) begin @(negedge clk); if (bus.led === 8'h00) n++; end
        checks++; if (n != 18) begin errors++; $display("FAIL off_led_hold: got %0d of 18 low expected 18", n); end
        press(1'b0, 1'b1, 1'b0);
        checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL off_up_ignored: got %0d expected 0", bus.level); end
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL wrap_mode: got %0d expected 0", bus.mode); end
        checks++; if (bus.level !== 4'd2) begin errors++; $display("FAIL manual_restore: got %0d expected 2", bus.level); end
    endtask

    task automatic test_reset_mid_frame;
        int t;
        int c0;
        int k;
        int bad;
        logic [7:0] exp_led;
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL rst_pre_mode: got %0d expected 1", bus.mode); end
        t = 0;
        while (bus.level !== 4'd5 && t < 200) begin @(negedge clk); t++; end
        while (bus.led !== 8'hFF && t < 220) begin @(negedge clk); t++; end
        checks++; if (bus.led !== 8'hFF) begin errors++; $display("FAIL rst_pre_led: got %h expected FF before reset", bus.led); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.led !== 8'h00) begin errors++; $display("FAIL rst_async_led: got %h expected 00", bus.led); end
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL rst_async_mode: got %0d expected 0", bus.mode); end
        checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL rst_async_level: got %0d expected 0", bus.level); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        c0 = cyc;
        repeat (3) press(1'b0, 1'b1, 1'b0);
        checks++; if (bus.level !== 4'd3) begin errors++; $display("FAIL rst_up3_level: got %0d expected 3", bus.level); end
        repeat (20) @(negedge clk);
        bad = 0;
        repeat (18) begin
            @(negedge clk);
            k = cyc - c0;
            exp_led = (((k - 1) % 9) < 3) ? 8'hFF : 8'h00;
            if (bus.led !== exp_led) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_frame_phase: got %0d of 18 samples off the pcnt=0 aligned pattern expected 0", bad); end
    endtask

    initial begin
        test_reset;
        test_manual_up;
        test_manual_down;
        test_breathe;
        test_chase;
        test_off;
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit after %0d checks", checks);
        $fatal(1, "watchdog");
    end
endmodule
